// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder.
//   state_e      : responder FSM states
//   src_e        : source of bytes shifted out during the data phase
//   OP_*         : supported opcodes (read, read JEDEC ID, read status)
//   jedec_byte() : selects byte idx (0 = MSB) of the 3-byte ID, 8'h00 after
package spi_flash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_JEDEC,
        SRC_STATUS
    } src_e;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer plus edge detector for one asynchronous pin.
//   clk, rst_n : block clock / async active-low reset
//   pin_i      : asynchronous input pin
//   level_o    : synchronized level (resets to RST_VAL)
//   rise_o     : one-cycle pulse on synchronized 0->1
//   fall_o     : one-cycle pulse on synchronized 1->0
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) serial-flash responder backed by a preloadable byte array.
// Supports READ (0x03 + 24-bit address), RDID (0x9F) and RDSR (0x05).
//   clk, rst_n        : block clock / async active-low reset
//   SCK, CS_n, MOSI   : SPI pins from the controller (asynchronous to clk)
//   MISO              : SPI data out, always driven, 0 outside the data phase
//   ld_en/addr/data   : one-byte-per-cycle preload port into the array
//   busy              : inverse of synchronized CS_n
//   cmd_err           : one-cycle pulse on an unsupported opcode
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned MEM_AW   = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              cmd_err
);

    localparam int unsigned DEPTH = 2 ** MEM_AW;

    logic sck_s, sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .pin_i(SCK),
        .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin_i(CS_n),
        .level_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin_i(MOSI),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // Edge outputs not needed here; abort uses the CS_n level directly.
    logic unused_edges;
    assign unused_edges = ^{sck_s, cs_rise, mosi_rise, mosi_fall};

    // Byte array: written by the preload port only, never reset.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              cmd_err_q, cmd_err_d;

    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] addr_shift;
    logic [MEM_AW-1:0] addr_inc;

    assign rx_byte    = {shift_q[6:0], mosi_s};
    // Upper address bits simply fall off the top of the MEM_AW-wide register.
    assign addr_shift = {addr_q[MEM_AW-2:0], mosi_s};
    assign addr_inc   = addr_q + MEM_AW'(1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        cmd_err_d  = 1'b0;

        if (cs_n_s) begin
            // Deselect wins in every state and drops any partial byte.
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            miso_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d    = S_CMD;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        addr_d     = '0;
                    end
                end

                S_CMD: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (rx_byte)
                                OP_READ: begin
                                    state_d    = S_ADDR;
                                    byte_cnt_d = '0;
                                end
                                OP_RDID: begin
                                    state_d    = S_DATA;
                                    src_d      = SRC_JEDEC;
                                    tx_d       = jedec_byte(JEDEC_ID, 2'd0);
                                    byte_cnt_d = 2'd1;
                                end
                                OP_RDSR: begin
                                    state_d = S_DATA;
                                    src_d   = SRC_STATUS;
                                    tx_d    = 8'h00;
                                end
                                default: begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end

                S_ADDR: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        addr_d    = addr_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                state_d = S_DATA;
                                src_d   = SRC_MEM;
                                tx_d    = mem[addr_shift];
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (sck_fall) begin
                        // ~bit_cnt == 7 - bit_cnt: MSB first.
                        miso_d    = tx_q[~bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (src_q)
                                SRC_MEM: begin
                                    addr_d = addr_inc;
                                    tx_d   = mem[addr_inc];
                                end
                                SRC_JEDEC: begin
                                    tx_d = jedec_byte(JEDEC_ID, byte_cnt_q);
                                    if (byte_cnt_q != 2'd3) begin
                                        byte_cnt_d = byte_cnt_q + 2'd1;
                                    end
                                end
                                default: tx_d = 8'h00;
                            endcase
                        end
                    end
                end

                S_IGNORE: miso_d = 1'b0;

                default: begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_MEM;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign MISO    = miso_q;
    assign busy    = ~cs_n_s;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    localparam int HALF = 6;  // SCK phase length in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCK = 1'b0;
    logic       CS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       busy;
    logic       cmd_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int err_cycles = 0;
    logic miso_seen = 1'b0;

    spi_flash_responder #(.MEM_AW(8), .JEDEC_ID(24'hEF4018)) dut (
        .clk(clk), .rst_n(rst_n), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
        if (MISO === 1'b1) miso_seen = 1'b1;
    end

    // Every stimulus step ends 2 ns after a rising edge, away from clk edges.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick(1);
        ld_en = 1'b0;
    endtask

    // Mode 0: MOSI set while SCK low, MISO sampled just before the rise.
    task automatic spi_bit(input logic b, output logic r);
        MOSI = b;
        tick(HALF);
        r = MISO;
        SCK = 1'b1;
        tick(HALF);
        SCK = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_assert();
        CS_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_release();
        tick(HALF);
        CS_n = 1'b1;
        MOSI = 1'b0;
        tick(HALF);
    endtask

    task automatic start_read(input logic [23:0] a);
        logic [7:0] d;
        xfer(8'h03, d);
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        chk_cnt++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b want 0", MISO); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL reset_cmd_err: got %b want 0", cmd_err); else pass_cnt++;
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_read_basic();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] d;
        preload(8'h10, 8'h11); preload(8'h11, 8'h22);
        preload(8'h12, 8'h33); preload(8'h13, 8'h44);
        cs_assert();
        chk_cnt++; if (busy !== 1'b1) $display("FAIL busy_high: got %b want 1", busy); else pass_cnt++;
        start_read(24'h000010);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, d);
            chk_cnt++;
            if (d !== exp[i]) $display("FAIL read_byte%0d: got %h want %h", i, d, exp[i]); else pass_cnt++;
        end
        cs_release();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL busy_low: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (MISO !== 1'b0) $display("FAIL miso_idle: got %b want 0", MISO); else pass_cnt++;
        // Upper address bits beyond the array width are ignored.
        cs_assert();
        start_read(24'hFFFF11);
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'h22) $display("FAIL read_trunc_addr: got %h want 22", d); else pass_cnt++;
        cs_release();
    endtask

    task automatic test_read_wrap();
        logic [7:0] d;
        preload(8'hFF, 8'hAA); preload(8'h00, 8'hBB);
        cs_assert();
        start_read(24'h0000FF);
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'hAA) $display("FAIL wrap_byte0: got %h want aa", d); else pass_cnt++;
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'hBB) $display("FAIL wrap_byte1: got %h want bb", d); else pass_cnt++;
        cs_release();
    endtask

    task automatic test_jedec();
        logic [7:0] exp [4] = '{8'hEF, 8'h40, 8'h18, 8'h00};
        logic [7:0] d;
        cs_assert();
        xfer(8'h9F, d);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, d);
            chk_cnt++;
            if (d !== exp[i]) $display("FAIL jedec_byte%0d: got %h want %h", i, d, exp[i]); else pass_cnt++;
        end
        cs_release();
    endtask

    task automatic test_status();
        logic [7:0] d;
        int e0;
        e0 = err_cycles;
        cs_assert();
        xfer(8'h05, d);
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'h00) $display("FAIL status_byte: got %h want 00", d); else pass_cnt++;
        cs_release();
        chk_cnt++; if (err_cycles !== e0) $display("FAIL status_no_err: got %0d want %0d", err_cycles, e0); else pass_cnt++;
    endtask

    task automatic test_bad_opcode();
        logic [7:0] d;
        int e0;
        e0 = err_cycles;
        cs_assert();
        xfer(8'h5A, d);
        miso_seen = 1'b0;
        xfer(8'hFF, d);
        xfer(8'hFF, d);
        chk_cnt++; if (err_cycles !== e0 + 1) $display("FAIL cmd_err_pulse: got %0d cycles want %0d", err_cycles - e0, 1); else pass_cnt++;
        chk_cnt++; if (miso_seen !== 1'b0) $display("FAIL ignore_miso: got %b want 0", miso_seen); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busy); else pass_cnt++;
        cs_release();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ignore_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic r;
        cs_assert();
        start_read(24'h000010);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        cs_release();
        chk_cnt++; if (MISO !== 1'b0) $display("FAIL abort_miso: got %b want 0", MISO); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
        cs_assert();
        xfer(8'h9F, d);
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'hEF) $display("FAIL abort_next_b0: got %h want ef", d); else pass_cnt++;
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'h40) $display("FAIL abort_next_b1: got %h want 40", d); else pass_cnt++;
        cs_release();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic r;
        cs_assert();
        start_read(24'h000010);
        xfer(8'h00, d);      // 0x11
        spi_bit(1'b0, r);    // bit7 of 0x22
        spi_bit(1'b0, r);    // bit6; the fall now presents bit5 = 1
        tick(4);
        chk_cnt++; if (MISO !== 1'b1) $display("FAIL mid_read_miso: got %b want 1", MISO); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (MISO !== 1'b0) $display("FAIL rst_mid_miso: got %b want 0", MISO); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
        CS_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        cs_assert();
        start_read(24'h000012);
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'h33) $display("FAIL post_rst_b0: got %h want 33", d); else pass_cnt++;
        xfer(8'h00, d);
        chk_cnt++; if (d !== 8'h44) $display("FAIL post_rst_b1: got %h want 44", d); else pass_cnt++;
        cs_release();
    endtask

    initial begin
        @(negedge clk);
        #2;
        test_reset();
        test_read_basic();
        test_read_wrap();
        test_jedec();
        test_status();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter MEM_AW, default 8, SHALL set the internal byte-array address width (2**MEM_AW bytes).
REQ-002 Parameter JEDEC_ID, default 24'hEF4018, SHALL set the 3-byte value returned by the 0x9F command, MSB first.
REQ-003 clk  input  1  single block clock, rising edge; all logic SHALL be in this domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SCK  input  1  SPI clock from the flash controller, mode 0, asynchronous to clk.
REQ-006 CS_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 MOSI  input  1  SPI serial data in, MSB first.
REQ-008 MISO  output  1  SPI serial data out, MSB first, driven (no tristate).
REQ-009 ld_en  input  1  preload strobe, one byte per clk cycle.
REQ-010 ld_addr  input  MEM_AW  preload byte address.
REQ-011 ld_data  input  8  preload byte value.
REQ-012 busy  output  1  high while synchronized CS_n is low.
REQ-013 cmd_err  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 SCK, CS_n and MOSI SHALL pass through 2-flop synchronizers; SCK rise/fall SHALL be detected from the synchronized value; SCK high and low phases are each at least 4 clk periods.
REQ-015 MOSI SHALL be sampled on each detected SCK rise; MISO SHALL change only on a detected SCK fall or on CS_n deassert.
REQ-016 States: S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE.
REQ-017 S_IDLE -> S_CMD on synchronized CS_n falling; bit counter (3 bits) and byte counter (2 bits) SHALL clear.
REQ-018 S_CMD: after 8 rises, opcode 0x03 -> S_ADDR; 0x9F -> S_DATA with JEDEC source; 0x05 -> S_DATA with status source; any other -> S_IGNORE and cmd_err pulses one cycle.
REQ-019 S_ADDR: shift in 24 address bits MSB first; only addr[MEM_AW-1:0] SHALL be used; after the 24th rise -> S_DATA with memory source.
REQ-020 S_DATA: on the SCK fall after the last command/address bit, MISO SHALL present bit 7 of the first byte; each later fall shifts to the next bit; after bit 0 the next fall presents bit 7 of the next byte.
REQ-021 Memory source: byte at current address; address SHALL increment by 1 per byte and wrap from 2**MEM_AW-1 to 0.
REQ-022 JEDEC source: bytes JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 repeatedly.
REQ-023 Status source: 8'h00 repeatedly (device never busy).
REQ-024 S_IGNORE: MISO SHALL stay 0 until CS_n deasserts.
REQ-025 CS_n deassert in any state, including mid-byte, SHALL return to S_IDLE within 3 clk of the pin edge, force MISO to 0 and discard partial bits.
REQ-026 MISO SHALL be 0 whenever not in S_DATA.
REQ-027 ld_en SHALL write ld_data to ld_addr in the same cycle regardless of state; a read of that address in the same cycle SHALL return the old value.
REQ-028 busy SHALL equal the inverse of the synchronized CS_n.

Reset
REQ-029 On rst_n low: state S_IDLE, MISO 0, busy 0, cmd_err 0, counters 0, shift registers 0, synchronizer flops reset to CS_n=1, SCK=0, MOSI=0.
REQ-030 Memory array contents SHALL NOT be reset.

Structure
REQ-031 Opcode constants (0x03, 0x9F, 0x05) and state encodings SHALL live in a shared package spi_flash_pkg.
REQ-032 Synchronizer plus edge detector SHALL be one sub-module, spi_sync, instantiated once per input pin.

Verification
REQ-033 Preload addr 0x10..0x13 = 11,22,33,44; 0x03 + 24'h000010, 32 SCK -> MISO bytes 11,22,33,44.
REQ-034 Preload 0xFF=AA, 0x00=BB; 0x03 + 24'h0000FF, 16 SCK -> AA, BB (wrap).
REQ-035 0x9F, 32 SCK -> EF, 40, 18, 00.
REQ-036 Opcode 0x5A -> cmd_err single-cycle pulse, MISO 0 for 16 further SCK, busy falls after CS_n high.
REQ-037 0x03 read, CS_n high after 4 data bits, then new 0x9F -> first byte EF, no residue.
REQ-038 rst_n low mid-read -> MISO 0, busy 0 immediately; preloaded bytes still readable after release.
